deal_sequencer: RTL
===================

DEAL_SEQUENCER -- requirements
Module: deal_sequencer

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 The block SHALL have the port start, input, 1 bit: level-sampled request to begin a round.
REQ-004 The block SHALL have the ports hit and stand, input, 1 bit each: player decisions, sampled only in PLAYER.
REQ-005 The block SHALL have the ports card_req (output, 1), card_valid (input, 1) and card_val (input, 5): card-source handshake; card_val is legal only when it is 1..11.
REQ-006 The block SHALL have the ports player_sum and dealer_sum, input, 6 bits each: totals from the scoring datapath.
REQ-007 The block SHALL have the ports card_out (output, 5), player_load (output, 1) and dealer_load (output, 1): registered card and one-cycle load strobes to the datapath.
REQ-008 The block SHALL have the ports busy (output, 1), eval (output, 1, one-cycle pulse), blackjack (output, 1) and err (output, 1, one-cycle pulse).

Function
REQ-009 The block SHALL implement these states: IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, CHK_BJ, PLAYER, DRAW_P, CHK_P, DEALER, DRAW_D, CHK_D, EVAL.
REQ-010 In IDLE with start=1, the block SHALL go to DEAL_P1 on the next edge and assert busy from that edge until it returns to IDLE.
REQ-011 The block SHALL use the dealing order player, dealer, player, dealer, each deal taking one card handshake.
REQ-012 In each DEAL_*/DRAW_* state, the block SHALL hold card_req=1 until it samples card_valid=1 with a legal card_val, then drop card_req on the next edge.
REQ-013 On an accepted card, the block SHALL register card_val into card_out and pulse exactly one of player_load or dealer_load for one cycle on the following edge.
REQ-014 On card_valid=1 with card_val=0 or card_val>11, the block SHALL discard the card, pulse err, keep card_req=1 and stay in the same state.
REQ-015 After every load, the block SHALL wait one settle cycle before comparing sums, because the datapath updates the sums one cycle after the load.
REQ-016 In CHK_BJ, if player_sum==21 the block SHALL set blackjack=1 and go to EVAL; otherwise it SHALL go to PLAYER.
REQ-017 In PLAYER, stand=1 SHALL move the block to DEALER; stand SHALL win over hit when both are 1 in the same cycle.
REQ-018 In PLAYER, hit=1 with stand=0 SHALL move the block to DRAW_P; hit SHALL be edge-qualified so that a held hit draws only one card.
REQ-019 In CHK_P, the block SHALL go to EVAL if player_sum>21, to DEALER if player_sum==21 or the player card count reaches 11, and to PLAYER otherwise.
REQ-020 In DEALER, the block SHALL go to DRAW_D if dealer_sum<17 and to EVAL if dealer_sum>=17; after DRAW_D, CHK_D SHALL return to DEALER.
REQ-021 The block SHALL cap the dealer at 11 cards; reaching the cap SHALL force EVAL.
REQ-022 In EVAL, the block SHALL pulse eval for one cycle, go to IDLE on the next edge, and hold blackjack until the next start.
REQ-023 The block SHALL ignore start while busy, and SHALL ignore hit and stand outside PLAYER.
REQ-024 Per-side card counters SHALL be 4 bits wide, SHALL saturate at 11, and SHALL clear when a round starts.

Reset
REQ-025 Asserting reset (0) SHALL immediately force IDLE and set card_req=0, card_out=0, player_load=0, dealer_load=0, busy=0, eval=0, blackjack=0, err=0, the counters to 0 and the hit edge register to 0.
REQ-026 A reset in the middle of a round SHALL abandon the round without any further load strobe, and the block SHALL wait for a new start.
REQ-027 When reset deasserts, the block SHALL act on the first rising edge of clk with reset=1.

Structure
REQ-028 A shared package blackjack_pkg SHALL hold the state enum, DEALER_STAND=17, BUST_LIMIT=21, MAX_CARDS=11, CARD_W=5 and SUM_W=6.
REQ-029 The card handshake (req hold, legality check, card_out register, err pulse) SHALL be one sub-module, card_fetch, instantiated once and shared by all deal and draw states.

Verification
REQ-030 The bench SHALL cover: start, cards 10,7,11,9, player_sum=21 after the second player load -> blackjack=1, eval pulse, no DEALER state, and player_load/dealer_load each pulsed exactly twice.
REQ-031 The bench SHALL cover: cards 10,6,5,10, player stands at 15, dealer draws 2 reaching 18 -> exactly one extra dealer_load, then eval.
REQ-032 The bench SHALL cover: player at 15 with hit, drawn card 9 reaching 24 -> CHK_P goes to EVAL with no dealer draw.
REQ-033 The bench SHALL cover: card_valid with card_val=0, then 12, then 4 -> two err pulses, card_req held throughout, and a single load with card_out=4.
REQ-034 The bench SHALL cover: hit and stand asserted together in PLAYER -> DEALER with no player_load; hit held for 5 cycles -> exactly one DRAW_P.
REQ-035 The bench SHALL cover: reset driven low during DRAW_D with card_req=1 -> all outputs 0 in the same cycle, and start ignored until reset=1.

Source files
------------

// File: rtl/blackjack_pkg.sv
// Shared state encoding, game constants and small helpers for the deal sequencer.
package blackjack_pkg;

  localparam int unsigned CARD_W       = 5;
  localparam int unsigned SUM_W        = 6;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned DEALER_STAND = 17;
  localparam int unsigned BUST_LIMIT   = 21;
  localparam int unsigned MAX_CARDS    = 11;
  localparam int unsigned MIN_CARD     = 1;
  localparam int unsigned MAX_CARD     = 11;

  typedef enum logic [3:0] {
    IDLE,
    DEAL_P1,
    DEAL_D1,
    DEAL_P2,
    DEAL_D2,
    CHK_BJ,
    PLAYER,
    DRAW_P,
    CHK_P,
    DEALER,
    DRAW_D,
    CHK_D,
    EVAL
  } state_t;

  function automatic logic card_legal(input logic [CARD_W-1:0] val);
    return (val >= CARD_W'(MIN_CARD)) && (val <= CARD_W'(MAX_CARD));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt >= CNT_W'(MAX_CARDS)) ? cnt : cnt + CNT_W'(1);
  endfunction

  // States that own the card-source handshake.
  function automatic logic is_fetch(input state_t s);
    return (s == DEAL_P1) || (s == DEAL_D1) || (s == DEAL_P2) ||
           (s == DEAL_D2) || (s == DRAW_P)  || (s == DRAW_D);
  endfunction

endpackage

// File: rtl/deal_sequencer_if.sv
// Player controls, card-source handshake and scoring-datapath signals of the sequencer.
interface deal_sequencer_if;
  import blackjack_pkg::*;

  logic              start;
  logic              hit;
  logic              stand;
  logic              card_req;
  logic              card_valid;
  logic [CARD_W-1:0] card_val;
  logic [SUM_W-1:0]  player_sum;
  logic [SUM_W-1:0]  dealer_sum;
  logic [CARD_W-1:0] card_out;
  logic              player_load;
  logic              dealer_load;
  logic              busy;
  logic              eval;
  logic              blackjack;
  logic              err;

  modport master (
    output start, hit, stand, card_valid, card_val, player_sum, dealer_sum,
    input  card_req, card_out, player_load, dealer_load, busy, eval, blackjack, err
  );

  modport slave (
    input  start, hit, stand, card_valid, card_val, player_sum, dealer_sum,
    output card_req, card_out, player_load, dealer_load, busy, eval, blackjack, err
  );

endinterface

// File: rtl/card_fetch.sv
// Card-source handshake shared by every deal/draw state: request hold, legality check,
// card register and illegal-card error pulse.
module card_fetch
  import blackjack_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_go,
  input  logic              i_card_valid,
  input  logic [CARD_W-1:0] i_card_val,
  output logic              o_card_req,
  output logic [CARD_W-1:0] o_card_out,
  output logic              o_err,
  output logic              o_accept_c
);

  logic              r_req;
  logic              r_err;
  logic [CARD_W-1:0] r_card;
  logic              w_sample;
  logic              w_legal;

  assign w_sample   = r_req && i_card_valid;
  assign w_legal    = card_legal(i_card_val);
  assign o_accept_c = w_sample && w_legal;

  // Request drops for one cycle after each accepted card; illegal cards keep it high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req  <= 1'b0;
      r_err  <= 1'b0;
      r_card <= '0;
    end else begin
      r_req <= i_go && !o_accept_c;
      r_err <= w_sample && !w_legal;
      if (o_accept_c) begin
        r_card <= i_card_val;
      end
    end
  end

  assign o_card_req = r_req;
  assign o_card_out = r_card;
  assign o_err      = r_err;

endmodule

// File: rtl/deal_sequencer.sv
// Blackjack round sequencer: deals four cards, runs player and dealer turns against the
// external scoring datapath and reports evaluation / blackjack.
module deal_sequencer
  import blackjack_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  deal_sequencer_if.slave bus
);

  state_t           r_state;
  state_t           w_state_d;
  logic             r_player_load;
  logic             r_dealer_load;
  logic             r_busy;
  logic             r_eval;
  logic             r_blackjack;
  logic             r_settle;
  logic             r_hit_q;
  logic [CNT_W-1:0] r_p_cnt;
  logic [CNT_W-1:0] r_d_cnt;

  logic             w_player_load_d;
  logic             w_dealer_load_d;
  logic             w_busy_d;
  logic             w_eval_d;
  logic             w_blackjack_d;
  logic             w_settle_d;
  logic [CNT_W-1:0] w_p_cnt_d;
  logic [CNT_W-1:0] w_d_cnt_d;
  logic             w_accept;
  logic             w_go;
  logic             w_hit_rise;
  logic             w_player_card;

  assign w_go          = is_fetch(r_state);
  assign w_hit_rise    = bus.hit && !r_hit_q;
  assign w_player_card = (r_state == DEAL_P1) || (r_state == DEAL_P2) || (r_state == DRAW_P);

  card_fetch u_fetch (
    .clk          (clk),
    .reset        (reset),
    .i_go         (w_go),
    .i_card_valid (bus.card_valid),
    .i_card_val   (bus.card_val),
    .o_card_req   (bus.card_req),
    .o_card_out   (bus.card_out),
    .o_err        (bus.err),
    .o_accept_c   (w_accept)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_player_load <= 1'b0;
      r_dealer_load <= 1'b0;
      r_busy        <= 1'b0;
      r_eval        <= 1'b0;
      r_blackjack   <= 1'b0;
      r_settle      <= 1'b0;
      r_hit_q       <= 1'b0;
      r_p_cnt       <= '0;
      r_d_cnt       <= '0;
    end else begin
      r_state       <= w_state_d;
      r_player_load <= w_player_load_d;
      r_dealer_load <= w_dealer_load_d;
      r_busy        <= w_busy_d;
      r_eval        <= w_eval_d;
      r_blackjack   <= w_blackjack_d;
      r_settle      <= w_settle_d;
      r_hit_q       <= bus.hit;
      r_p_cnt       <= w_p_cnt_d;
      r_d_cnt       <= w_d_cnt_d;
    end
  end

  // CHK_* states hold while r_settle is set: the sums lag the load strobe by a cycle.
  always_comb begin
    w_state_d       = r_state;
    w_blackjack_d   = r_blackjack;
    w_p_cnt_d       = r_p_cnt;
    w_d_cnt_d       = r_d_cnt;
    w_player_load_d = 1'b0;
    w_dealer_load_d = 1'b0;
    w_settle_d      = w_accept;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_d     = DEAL_P1;
          w_blackjack_d = 1'b0;
          w_p_cnt_d     = '0;
          w_d_cnt_d     = '0;
        end
      end
      DEAL_P1: if (w_accept) w_state_d = DEAL_D1;
      DEAL_D1: if (w_accept) w_state_d = DEAL_P2;
      DEAL_P2: if (w_accept) w_state_d = DEAL_D2;
      DEAL_D2: if (w_accept) w_state_d = CHK_BJ;
      CHK_BJ: begin
        if (!r_settle) begin
          if (bus.player_sum == SUM_W'(BUST_LIMIT)) begin
            w_blackjack_d = 1'b1;
            w_state_d     = EVAL;
          end else begin
            w_state_d = PLAYER;
          end
        end
      end
      PLAYER: begin
        if (bus.stand) begin
          w_state_d = DEALER;
        end else if (w_hit_rise) begin
          w_state_d = DRAW_P;
        end
      end
      DRAW_P: if (w_accept) w_state_d = CHK_P;
      CHK_P: begin
        if (!r_settle) begin
          if (bus.player_sum > SUM_W'(BUST_LIMIT)) begin
            w_state_d = EVAL;
          end else if ((bus.player_sum == SUM_W'(BUST_LIMIT)) ||
                       (r_p_cnt >= CNT_W'(MAX_CARDS))) begin
            w_state_d = DEALER;
          end else begin
            w_state_d = PLAYER;
          end
        end
      end
      DEALER: begin
        if (bus.dealer_sum < SUM_W'(DEALER_STAND)) begin
          w_state_d = DRAW_D;
        end else begin
          w_state_d = EVAL;
        end
      end
      DRAW_D: if (w_accept) w_state_d = CHK_D;
      CHK_D: begin
        if (!r_settle) begin
          w_state_d = (r_d_cnt >= CNT_W'(MAX_CARDS)) ? EVAL : DEALER;
        end
      end
      EVAL:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase

    if (w_accept) begin
      if (w_player_card) begin
        w_player_load_d = 1'b1;
        w_p_cnt_d       = sat_inc(r_p_cnt);
      end else begin
        w_dealer_load_d = 1'b1;
        w_d_cnt_d       = sat_inc(r_d_cnt);
      end
    end

    w_busy_d = (w_state_d != IDLE);
    w_eval_d = (w_state_d == EVAL);
  end

  assign bus.player_load = r_player_load;
  assign bus.dealer_load = r_dealer_load;
  assign bus.busy        = r_busy;
  assign bus.eval        = r_eval;
  assign bus.blackjack   = r_blackjack;

endmodule
